// File: rtl/rca_mp_add_seq.sv
// Multi-precision add sequencer: feeds one shared external WIDTH-bit ripple-carry adder
// one word per cycle (LSW first), chaining carry. Optional subtract mode under RCA_SEQ_SUB_EN.
module rca_mp_add_seq #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] in_a,
    input  logic [WIDTH*WORDS-1:0] in_b,
    input  logic                   in_ci,
`ifdef RCA_SEQ_SUB_EN
    input  logic                   in_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] out_sum,
    output logic                   out_co,
    output logic                   busy,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_ci,
    input  logic [WIDTH-1:0]       add_s,
    input  logic                   add_co
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [WORDS-1:0][WIDTH-1:0]   a_q, a_d;
    logic [WORDS-1:0][WIDTH-1:0]   b_q, b_d;
    logic [WORDS-1:0][WIDTH-1:0]   sum_q, sum_d;
    logic                          ci_q, ci_d;
    logic                          carry_q, carry_d;
    logic                          co_q, co_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
`ifdef RCA_SEQ_SUB_EN
    logic                          sub_q, sub_d;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ci_d    = ci_q;
        carry_d = carry_q;
        co_d    = co_q;
        idx_d   = idx_q;
`ifdef RCA_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        add_a   = '0;
        add_b   = '0;
        add_ci  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    ci_d    = in_ci;
`ifdef RCA_SEQ_SUB_EN
                    sub_d   = in_sub;
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    co_d    = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                add_a = a_q[idx_q];
`ifdef RCA_SEQ_SUB_EN
                // Subtract as A + ~B + 1; the caller's carry-in is overridden.
                add_b  = sub_q ? ~b_q[idx_q] : b_q[idx_q];
                add_ci = (idx_q == '0) ? (sub_q | ci_q) : carry_q;
                if (sub_q && idx_q == '0) add_ci = 1'b1;
`else
                add_b  = b_q[idx_q];
                add_ci = (idx_q == '0) ? ci_q : carry_q;
`endif
                sum_d[idx_q] = add_s;
                carry_d      = add_co;
                if (idx_q == LAST_IDX) begin
                    co_d    = add_co;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state, operand registers included, is cleared by the synchronous reset so an
    // aborted operation leaves nothing behind; sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ci_q    <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            idx_q   <= '0;
`ifdef RCA_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ci_q    <= ci_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            idx_q   <= idx_d;
`ifdef RCA_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = sum_q;
    assign out_co    = co_q;

endmodule
